// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, default
// sizes and the round-robin pick helper.
package uart_arb_pkg;

  localparam int N_BIT_DEF = 8;
  localparam int N_REQ_DEF = 4;
  localparam int LEN_W_DEF = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  // One-hot pick of the first set req bit at or above ptr, wrapping at n.
  function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [7:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i < n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and FIFO-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ*N_BIT-1:0] src_data;
  logic [N_REQ-1:0]       src_valid;
  logic [N_REQ-1:0]       src_ready;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       pkt_done;
  logic                   busy;
  logic [N_BIT-1:0]       tx_wr_data;
  logic                   tx_wr_en;
  logic                   tx_full;

  modport master (
    input  req, req_len, src_data, src_valid, tx_full,
    output src_ready, grant, pkt_done, busy, tx_wr_data, tx_wr_en
  );

  modport slave (
    output req, req_len, src_data, src_valid, tx_full,
    input  src_ready, grant, pkt_done, busy, tx_wr_data, tx_wr_en
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin priority pick over the request vector.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [N_REQ-1:0] pick
);

  assign pick = N_REQ'(rr_pick(8'(req), ptr, N_REQ));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX FIFO write port
// between N_REQ message sources.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  logic [0:0]       state_q,    state_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  logic [N_REQ-1:0] pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [LEN_W-1:0] cnt_q,      cnt_d;
  logic [2:0]       ptr_q,      ptr_d;
  logic             busy_q,     busy_d;

  logic [N_REQ-1:0] pick;
  logic [LEN_W-1:0] pick_len;
  logic [N_BIT-1:0] owner_data;
  logic             owner_valid;
  logic [2:0]       nxt_ptr;
  logic             in_xfer;
  logic             beat;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Owner mux and the length of whichever requester would win this cycle.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    nxt_ptr     = ptr_q;
    pick_len    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_valid = bus.src_valid[i];
        owner_data  = bus.src_data[i*N_BIT +: N_BIT];
        nxt_ptr     = 3'((i + 1) % N_REQ);
      end
      if (pick[i]) pick_len = bus.req_len[i*LEN_W +: LEN_W];
    end
  end

  assign in_xfer = (state_q == XFER);
  assign beat    = in_xfer & owner_valid & ~bus.tx_full;

  assign bus.src_ready  = in_xfer ? (grant_q & {N_REQ{~bus.tx_full}}) : '0;
  assign bus.tx_wr_en   = beat;
  assign bus.tx_wr_data = in_xfer ? owner_data : '0;
  assign bus.grant      = grant_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.busy       = busy_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    pkt_done_d = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = pick;
          len_d   = pick_len;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          // Compare before incrementing so a 2^LEN_W byte packet never wraps.
          if (cnt_q == len_q) begin
            pkt_done_d = grant_q;
            grant_d    = '0;
            busy_d     = 1'b0;
            cnt_d      = '0;
            ptr_d      = nxt_ptr;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      pkt_done_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pkt_done_q <= pkt_done_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO (tx_wr_data / tx_wr_en / tx_full of the UART wrapper) between N_REQ independent requesters.
- Grants are packet-atomic: a granted requester owns the FIFO write port until its declared byte count has been written.
- Arbitration is round-robin, so a continuously requesting source cannot starve the others.
- Sits between on-chip message sources (status reporter, command responder, debug dump) and the UART wrapper.

Parameters:
- N_BIT, 8, data width in bits; matches the UART wrapper.
- N_REQ, 4, number of requesters; range 2..8.
- LEN_W, 4, width of the length field. Packet length is req_len+1 bytes, so 1..2^LEN_W bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester packet request; level-sensitive.
- req_len  in  N_REQ*LEN_W  per-requester length minus one; slice i is [i*LEN_W +: LEN_W].
- src_data  in  N_REQ*N_BIT  per-requester byte; slice i is [i*N_BIT +: N_BIT].
- src_valid  in  N_REQ  per-requester byte valid.
- src_ready  out  N_REQ  per-requester byte accepted this cycle.
- grant  out  N_REQ  one-hot owner of the FIFO write port; all zero when idle.
- pkt_done  out  N_REQ  one-cycle pulse on the owner's bit after its last byte is written.
- busy  out  1  high while a packet is in progress.
- tx_wr_data  out  N_BIT  to UART wrapper tx_wr_data.
- tx_wr_en  out  1  to UART wrapper tx_wr_en.
- tx_full  in  1  from UART wrapper tx_full.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, pkt_done=0, busy=0, round-robin pointer=0, byte count=0.
  - src_ready=0 and tx_wr_en=0 during reset, because both are decoded from state.
  - tx_wr_data=0 while not in XFER.
  - Reset mid-packet drops the remainder of the packet. Bytes already in the FIFO are still sent.
- FSM has two states, IDLE and XFER.
  - IDLE: if any req bit is set, register grant on the first set bit found searching upward from the pointer, with wrap-around. In the same edge, latch that requester's req_len into len_q, clear the count, set busy=1, and go to XFER.
  - Latency from req rise to grant is 1 cycle.
  - XFER: define beat = src_valid[g] & !tx_full.
    - src_ready[g] = !tx_full. src_ready of non-owners is 0.
    - tx_wr_en = beat. tx_wr_data = src_data slice g.
    - These signals are combinational from registered state, so the FIFO write happens in the same cycle as the beat.
  - On a beat with count==len_q: pulse pkt_done[g] on the next cycle, clear grant and busy, set pointer=(g+1) mod N_REQ, and go to IDLE. Otherwise count increments.
  - A new grant is possible on the cycle after pkt_done, giving a minimum 1-cycle gap between packets.
- Packet atomicity: req[g] deasserting during XFER is ignored; the arbiter waits for all len_q+1 bytes. req_len changes after grant are ignored.
- Backpressure: while tx_full=1, no write occurs and src_ready=0. The byte is held by the source. No data is lost or duplicated.
- Fairness: with all req high, grants rotate 0,1,2,3,0,... A requester waits at most N_REQ-1 packets.
- No write ever occurs in IDLE. At most one FIFO write occurs per cycle.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding: IDLE=1'b0, XFER=1'b1;
  - the helper function rr_pick(req, ptr), which returns a one-hot N_REQ vector;
  - default constants for N_BIT, N_REQ and LEN_W.
- One natural sub-module, rr_arbiter: combinational round-robin priority pick from req and pointer. The top holds the FSM, the counter and the muxes.

Test Plan:
- Single packet: req[1]=1, req_len=2, src_valid held high with bytes 0xA1,0xA2,0xA3, tx_full=0 -> grant=0010 one cycle after req; three consecutive tx_wr_en pulses carrying A1,A2,A3; pkt_done[1] pulses on the next cycle; busy returns to 0.
- Round-robin: req=1111 continuously, every req_len=0 -> grant order 0,1,2,3,0; each grant writes exactly 1 byte; each packet is followed by exactly 1 idle cycle.
- Backpressure: owner 2, req_len=3; tx_full=1 for 5 cycles after the second byte -> no tx_wr_en and src_ready[2]=0 during the stall; then bytes 3 and 4 are written in order; exactly 4 writes in total.
- Atomicity: req[0] drops after the first byte of a 4-byte packet while req[3]=1 -> grant stays 0001 until the 4th byte is written, then moves to 1000.
- Reset mid-packet: rst=0 after 2 of 8 bytes -> grant, busy, tx_wr_en and src_ready go to 0 immediately (asynchronously). After release with req[2]=1, the pointer is 0 and grant=0100.
- Max length: req_len=4'hF -> exactly 16 writes, then pkt_done; the counter does not overflow.
